seg_frame_reader: RTL



---
 rtl/seg_frame_reader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_frame_reader.sv
// Seven-segment bus reader: synchronizes and debounces an active-low multiplexed
// display bus, decodes each strobed digit and publishes complete frames atomically.
module seg_frame_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_n,
    output logic [4*NDIG-1:0]   value,
    output logic [NDIG-1:0]     digit_err,
    output logic                frame_valid
);
    localparam int W  = NDIG + 7;
    localparam int CW = $clog2(STABLE + 1);

    typedef enum logic [1:0] {
        UNSTABLE = 2'd0,
        ARMED    = 2'd1,
        HELD     = 2'd2
    } state_t;

    // With STABLE==1 the very first equal sample already completes the stretch.
    localparam state_t START_STATE = (STABLE == 1) ? ARMED : UNSTABLE;

    // Glyph to {error, nibble}; unknown patterns read back as 0 with error set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = 5'h00;
            7'h79:   res = 5'h01;
            7'h24:   res = 5'h02;
            7'h30:   res = 5'h03;
            7'h19:   res = 5'h04;
            7'h12:   res = 5'h05;
            7'h02:   res = 5'h06;
            7'h78:   res = 5'h07;
            7'h00:   res = 5'h08;
            7'h18:   res = 5'h09;
            7'h08:   res = 5'h0A;
            7'h03:   res = 5'h0B;
            7'h46:   res = 5'h0C;
            7'h21:   res = 5'h0D;
            7'h06:   res = 5'h0E;
            7'h0E:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [W-1:0]      s1_r, s2_r;
    logic [CW-1:0]     cnt_r, cnt_s;
    state_t            state_r, state_s;
    logic              eq_s, capture_s, qual_s, done_s;
    logic [4:0]        dec_s;
    logic [NDIG-1:0]   strobe_s, seen_r, seen_s;
    logic [4*NDIG-1:0] sh_val_r, sh_val_s;
    logic [NDIG-1:0]   sh_err_r, sh_err_s;

    // Two-flop input synchronizer; idle value is a blank, unstrobed bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_r <= {W{1'b1}};
            s2_r <= {W{1'b1}};
        end else begin
            s1_r <= {dig_n, seg_in};
            s2_r <= s1_r;
        end
    end

    // Stability controller: next state, saturating counter and capture strobe.
    always_comb begin
        eq_s      = (s1_r == s2_r);
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        if (!eq_s) begin
            state_s = START_STATE;
            cnt_s   = {CW{1'b0}};
        end else begin
            if (cnt_r < CW'(STABLE)) begin
                cnt_s = cnt_r + CW'(1);
            end else begin
                cnt_s = cnt_r;
            end
            case (state_r)
                UNSTABLE: state_s = (cnt_r == CW'(STABLE - 2)) ? ARMED : UNSTABLE;
                ARMED: begin
                    capture_s = 1'b1;
                    state_s   = HELD;
                end
                HELD:     state_s = HELD;
                default:  state_s = START_STATE;
            endcase
        end
    end

    // Controller state and stability count registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= START_STATE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Strobe qualification, shadow update and frame completion detect.
    always_comb begin
        dec_s    = seg_decode(s2_r[6:0]);
        strobe_s = ~s2_r[W-1:7];
        qual_s   = capture_s && $onehot(strobe_s);
        sh_val_s = sh_val_r;
        sh_err_s = sh_err_r;
        for (int k = 0; k < NDIG; k++) begin
            if (qual_s && strobe_s[k]) begin
                sh_val_s[4*k +: 4] = dec_s[3:0];
                sh_err_s[k]        = dec_s[4];
            end else begin
                sh_val_s[4*k +: 4] = sh_val_r[4*k +: 4];
                sh_err_s[k]        = sh_err_r[k];
            end
        end
        if (qual_s) begin
            seen_s = seen_r | strobe_s;
        end else begin
            seen_s = seen_r;
        end
        done_s = qual_s && (&seen_s);
    end

    // Shadow, seen mask and published outputs; outputs move only on completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_val_r    <= {(4*NDIG){1'b0}};
            sh_err_r    <= {NDIG{1'b0}};
            seen_r      <= {NDIG{1'b0}};
            value       <= {(4*NDIG){1'b0}};
            digit_err   <= {NDIG{1'b0}};
            frame_valid <= 1'b0;
        end else begin
            sh_val_r    <= sh_val_s;
            sh_err_r    <= sh_err_s;
            frame_valid <= done_s;
            if (done_s) begin
                seen_r    <= {NDIG{1'b0}};
                value     <= sh_val_s;
                digit_err <= sh_err_s;
            end else begin
                seen_r    <= seen_s;
                value     <= value;
                digit_err <= digit_err;
            end
        end
    end
endmodule
